alu_issue_stage: RTL and testbench

//  ID->EX pipeline stage directly upstream of the ALU. Decodes RV32I opcode/funct3/funct7[5] into the 4-bit ALU opcode.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_decode.sv | 80 ++++++++
 rtl/alu_issue_stage.sv | 138 +++++++++++++
 tb/tb_alu_issue_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: 4-bit ALU opcodes, RV32I major
// opcodes and the operand-select types used by the decoder and the top.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1011;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2,
        B_ZERO = 2'd3
    } b_sel_e;

    // funct3 decode shared by OP and OP_IMM; SUB exists only for register form.
    function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                            input logic       f7_5,
                                            input logic       is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode: {opcode, funct3, funct7[5]} to ALU opcode,
// operand selects, shift flag and illegal-encoding flag.
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_alu_op,
    output a_sel_e     o_a_sel,
    output b_sel_e     o_b_sel,
    output logic       o_is_shift,
    output logic       o_illegal
);

    logic w_f3_shift;

    assign w_f3_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    always_comb begin
        o_alu_op   = ALU_ADD;
        o_a_sel    = A_ZERO;
        o_b_sel    = B_ZERO;
        o_is_shift = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            OP: begin
                o_a_sel    = A_RS1;
                o_b_sel    = B_RS2;
                o_alu_op   = arith_op(i_funct3, i_funct7_5, 1'b1);
                o_is_shift = w_f3_shift;
            end
            OP_IMM: begin
                o_a_sel    = A_RS1;
                o_b_sel    = B_IMM;
                o_alu_op   = arith_op(i_funct3, i_funct7_5, 1'b0);
                o_is_shift = w_f3_shift;
            end
            LUI: begin
                o_a_sel = A_ZERO;
                o_b_sel = B_IMM;
            end
            AUIPC: begin
                o_a_sel = A_PC;
                o_b_sel = B_IMM;
            end
            LOAD, STORE: begin
                o_a_sel = A_RS1;
                o_b_sel = B_IMM;
            end
            BRANCH: begin
                // funct3 01x has no RV32I branch; it is flagged and zeroed like a bad opcode.
                case (i_funct3[2:1])
                    2'b00: begin
                        o_a_sel  = A_RS1;
                        o_b_sel  = B_RS2;
                        o_alu_op = ALU_SUB;
                    end
                    2'b10: begin
                        o_a_sel  = A_RS1;
                        o_b_sel  = B_RS2;
                        o_alu_op = ALU_SLT;
                    end
                    2'b11: begin
                        o_a_sel  = A_RS1;
                        o_b_sel  = B_RS2;
                        o_alu_op = ALU_SLTU;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            JAL, JALR: begin
                o_a_sel = A_PC;
                o_b_sel = B_FOUR;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decode, operand select/forward, single-entry valid/ready
// output register. Optional rs1 bypass from EX enabled by macro ALU_FWD_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd_in,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [4:0]      rd_out,
    output logic            illegal
);

    // Handshake: a transfer on either side happens on a rising edge where
    // valid and ready are both high; the output register accepts a new entry
    // whenever it is empty or its current entry leaves in the same cycle.

    logic [3:0]      w_dec_op;
    a_sel_e          w_a_sel;
    b_sel_e          w_b_sel;
    logic            w_is_shift;
    logic            w_illegal;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b_raw;
    logic [XLEN-1:0] w_b;
    logic            w_in_ready;
    logic            w_load;

    logic            r_out_valid;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_op;
    logic [4:0]      r_rd_out;
    logic            r_illegal;

    alu_decode u_decode (
        .i_opcode   (opcode),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .o_alu_op   (w_dec_op),
        .o_a_sel    (w_a_sel),
        .o_b_sel    (w_b_sel),
        .o_is_shift (w_is_shift),
        .o_illegal  (w_illegal)
    );

`ifdef ALU_FWD_EN
    // x0 is never a real producer, so a matching index of 0 must not bypass.
    assign w_rs1_val = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs1_addr))
                       ? fwd_data : rs1_data;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, rs1_addr};
    assign w_rs1_val    = rs1_data;
`endif

    always_comb begin
        w_a = '0;
        case (w_a_sel)
            A_RS1:   w_a = w_rs1_val;
            A_PC:    w_a = pc;
            default: w_a = '0;
        endcase
    end

    always_comb begin
        w_b_raw = '0;
        case (w_b_sel)
            B_RS2:   w_b_raw = rs2_data;
            B_IMM:   w_b_raw = imm;
            B_FOUR:  w_b_raw = XLEN'(4);
            default: w_b_raw = '0;
        endcase
    end

    // Shift amount only; I-type immediates carry funct7 in their upper bits.
    assign w_b = w_is_shift ? {{(XLEN-SHAMT_W){1'b0}}, w_b_raw[SHAMT_W-1:0]} : w_b_raw;

    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_load     = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= ALU_ADD;
            r_rd_out    <= '0;
            r_illegal   <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load && !flush) begin
                r_alu_a   <= w_a;
                r_alu_b   <= w_b;
                r_alu_op  <= w_dec_op;
                r_rd_out  <= rd_in;
                r_illegal <= w_illegal;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rd_out    = r_rd_out;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table through a scoreboard
// with random backpressure, then hand-written flush/stall/reset/forward cases.
module tb_alu_issue_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [4:0]      rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd_in;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [4:0]      rd_out;
    logic            illegal;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .pc(pc), .rd_in(rd_in),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .rd_out(rd_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] im;
        logic [31:0] pcv;
        logic        e_ill;
        logic [3:0]  e_op;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    logic [73:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] im, input logic [31:0] pcv,
                                input logic e_ill, input logic [3:0] e_op,
                                input logic [31:0] e_a, input logic [31:0] e_b);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2;
        v.im = im; v.pcv = pcv; v.e_ill = e_ill; v.e_op = e_op; v.e_a = e_a; v.e_b = e_b;
        return v;
    endfunction

    function automatic logic [73:0] pack(input logic ill, input logic [3:0] op,
                                         input logic [4:0] rd, input logic [31:0] a,
                                         input logic [31:0] b);
        return {ill, op, rd, a, b};
    endfunction

    function automatic logic [73:0] outs();
        return {illegal, alu_op, rd_out, alu_a, alu_b};
    endfunction

    task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input logic [4:0] rd);
        opcode   = v.opc;
        funct3   = v.f3;
        funct7_5 = v.f7;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        imm      = v.im;
        pc       = v.pcv;
        rd_in    = rd;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 74'(out_valid), 74'(0));
        check({tag, "_in_ready"}, 74'(in_ready), 74'(1));
        check({tag, "_fields"}, outs(), pack(1'b0, 4'b0000, 5'd0, 32'd0, 32'd0));
    endtask

    logic [73:0] held;
    logic [73:0] e;
    logic [31:0] fwd_exp;
    int idx;
    int cyc;

    initial begin
        vecs[0]  = mk(7'b0110011, 3'b000, 1'b0, 32'd10, 32'd3, 32'd0, 32'h100, 1'b0, 4'b0000, 32'd10, 32'd3);
        vecs[1]  = mk(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'h100, 1'b0, 4'b0001, 32'd10, 32'd3);
        vecs[2]  = mk(7'b0010011, 3'b000, 1'b1, 32'd10, 32'd3, 32'hFFFF_FFFC, 32'h100, 1'b0, 4'b0000, 32'd10, 32'hFFFF_FFFC);
        vecs[3]  = mk(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd3, 32'h0000_0403, 32'h100, 1'b0, 4'b1011, 32'h8000_0000, 32'd3);
        vecs[4]  = mk(7'b0110011, 3'b101, 1'b0, 32'h0000_00F0, 32'hFFFF_FF24, 32'd0, 32'h100, 1'b0, 4'b1001, 32'h0000_00F0, 32'd4);
        vecs[5]  = mk(7'b0010011, 3'b001, 1'b0, 32'd1, 32'd3, 32'h0000_007F, 32'h100, 1'b0, 4'b1000, 32'd1, 32'h1F);
        vecs[6]  = mk(7'b0110011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h100, 1'b0, 4'b0101, 32'hFFFF_FFFF, 32'd1);
        vecs[7]  = mk(7'b0010011, 3'b011, 1'b0, 32'd10, 32'd3, 32'hFFFF_F800, 32'h100, 1'b0, 4'b0111, 32'd10, 32'hFFFF_F800);
        vecs[8]  = mk(7'b0110011, 3'b100, 1'b0, 32'h0000_A5A5, 32'h0000_FF00, 32'd0, 32'h100, 1'b0, 4'b0100, 32'h0000_A5A5, 32'h0000_FF00);
        vecs[9]  = mk(7'b0010011, 3'b110, 1'b0, 32'd10, 32'd3, 32'h0000_00F0, 32'h100, 1'b0, 4'b0011, 32'd10, 32'h0000_00F0);
        vecs[10] = mk(7'b0110011, 3'b111, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'd0, 32'h100, 1'b0, 4'b0010, 32'h1234_5678, 32'h0000_FFFF);
        vecs[11] = mk(7'b0110111, 3'b000, 1'b0, 32'h55, 32'd3, 32'h1234_5000, 32'h100, 1'b0, 4'b0000, 32'd0, 32'h1234_5000);
        vecs[12] = mk(7'b0010111, 3'b000, 1'b0, 32'h55, 32'd3, 32'h0000_2000, 32'h100, 1'b0, 4'b0000, 32'h100, 32'h0000_2000);
        vecs[13] = mk(7'b0000011, 3'b010, 1'b0, 32'h40, 32'd3, 32'd8, 32'h100, 1'b0, 4'b0000, 32'h40, 32'd8);
        vecs[14] = mk(7'b0100011, 3'b010, 1'b0, 32'h80, 32'h77, 32'hFFFF_FFF0, 32'h100, 1'b0, 4'b0000, 32'h80, 32'hFFFF_FFF0);
        vecs[15] = mk(7'b1100011, 3'b000, 1'b0, 32'd5, 32'd5, 32'h10, 32'h100, 1'b0, 4'b0001, 32'd5, 32'd5);
        vecs[16] = mk(7'b1100011, 3'b101, 1'b0, 32'd7, 32'd9, 32'h10, 32'h100, 1'b0, 4'b0101, 32'd7, 32'd9);
        vecs[17] = mk(7'b1100011, 3'b110, 1'b0, 32'd7, 32'd9, 32'h10, 32'h100, 1'b0, 4'b0111, 32'd7, 32'd9);
        vecs[18] = mk(7'b1100011, 3'b010, 1'b0, 32'd7, 32'd9, 32'h10, 32'h100, 1'b1, 4'b0000, 32'd0, 32'd0);
        vecs[19] = mk(7'b1101111, 3'b000, 1'b0, 32'd7, 32'd9, 32'h40, 32'h200, 1'b0, 4'b0000, 32'h200, 32'd4);
        vecs[20] = mk(7'b1100111, 3'b000, 1'b0, 32'h99, 32'd9, 32'd8, 32'h300, 1'b0, 4'b0000, 32'h300, 32'd4);
        vecs[21] = mk(7'b1111111, 3'b111, 1'b1, 32'h99, 32'd9, 32'd8, 32'h300, 1'b1, 4'b0000, 32'd0, 32'd0);

        // Clock/reset
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs1_addr = 5'd5; fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = '0;
        apply(vecs[0], 5'd0);
        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // Vector table through the scoreboard with random backpressure
        idx = 0;
        cyc = 0;
        while ((idx < NV || exp_q.size() != 0 || out_valid) && cyc < 600) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (idx < NV && $urandom_range(0, 4) != 0) begin
                apply(vecs[idx], 5'(idx + 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h expected none", outs());
                end else begin
                    e = exp_q.pop_front();
                    check("sb_vec", outs(), e);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(pack(vecs[idx].e_ill, vecs[idx].e_op, 5'(idx + 1),
                                     vecs[idx].e_a, vecs[idx].e_b));
                idx++;
            end
            tick();
            cyc++;
        end
        if (cyc >= 600) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_timeout: got %0d sent, %0d pending expected all drained", idx, exp_q.size());
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

        // Backpressure: held entry must not change and blocks a waiting input
        out_ready = 1'b0;
        apply(vecs[1], 5'd7);
        in_valid = 1'b1;
        tick();
        apply(vecs[10], 5'd9);
        check("bp_load_valid", 74'(out_valid), 74'(1));
        check("bp_in_ready_low", 74'(in_ready), 74'(0));
        check("bp_sub_fields", outs(), pack(1'b0, 4'b0001, 5'd7, 32'd10, 32'd3));
        held = outs();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", 74'(out_valid), 74'(1));
            check("bp_hold_fields", outs(), held);
            check("bp_hold_in_ready", 74'(in_ready), 74'(0));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 74'(in_ready), 74'(1));
        tick();
        in_valid = 1'b0;
        check("bp_replace_valid", 74'(out_valid), 74'(1));
        check("bp_replace_fields", outs(), pack(1'b0, 4'b0010, 5'd9, 32'h1234_5678, 32'h0000_FFFF));
        tick();
        check("bp_drain_valid", 74'(out_valid), 74'(0));

        // Flush overriding a same-cycle load
        apply(vecs[0], 5'd4);
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 74'(in_ready), 74'(1));
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_load_valid", 74'(out_valid), 74'(0));

        // Flush discarding a held entry
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("flush_held_pre", 74'(out_valid), 74'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_held_valid", 74'(out_valid), 74'(0));

        // Unsupported opcode still handshakes
        out_ready = 1'b1;
        apply(vecs[21], 5'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bad_op_valid", 74'(out_valid), 74'(1));
        check("bad_op_fields", outs(), pack(1'b1, 4'b0000, 5'd3, 32'd0, 32'd0));
        tick();
        check("bad_op_drain", 74'(out_valid), 74'(0));

        // Forwarding of rs1
`ifdef ALU_FWD_EN
        fwd_exp = 32'hAA;
`else
        fwd_exp = 32'h11;
`endif
        apply(mk(7'b0110011, 3'b000, 1'b0, 32'h11, 32'd1, 32'd0, 32'h100,
                 1'b0, 4'b0000, 32'd0, 32'd0), 5'd2);
        rs1_addr = 5'd5; fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hAA;
        in_valid = 1'b1;
        tick();
        check("fwd_match_a", 74'(alu_a), 74'(fwd_exp));
        rs1_addr = 5'd0; fwd_rd = 5'd0;
        tick();
        check("fwd_x0_a", 74'(alu_a), 74'(32'h11));
        rs1_addr = 5'd5; fwd_rd = 5'd6;
        tick();
        check("fwd_miss_a", 74'(alu_a), 74'(32'h11));
        apply(vecs[12], 5'd2);
        fwd_rd = 5'd5;
        tick();
        in_valid = 1'b0;
        fwd_valid = 1'b0;
        check("fwd_auipc_a", 74'(alu_a), 74'(32'h100));
        tick();

        // Reset while an entry is held
        out_ready = 1'b0;
        apply(vecs[3], 5'd12);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_mid_pre", 74'(out_valid), 74'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero_outputs("rst_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
